plc_down_timer: RTL and testbench

- Loadable WIDTH-bit down-counting timer with prescaler, for PLC countdown (TOF/CTD-style) instructions executed by the core.
- Counterpart to the core's increment path: counts a preset value down to zero, then flags expiry.
- Sits beside the core's register file. The core writes the preset, pulses Start, and polls Done or samples Expired.

---
 rtl/plc_down_timer.sv | 132 +++++++++++++
 tb/tb_plc_down_timer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/plc_down_timer.sv
// plc_down_timer: loadable down-counting timer with prescaler for PLC
// countdown instructions. Preset is loaded on an accepted Start, then
// counted to zero in PRESCALE-cycle ticks while Enable is high. Done flags
// expiry as a level and Expired pulses once on entry to DONE.
// Optional build macro: PLC_TIMER_AUTO_RELOAD_EN (reload Preset on expiry
// and keep running; Abort is then the only exit).
module plc_down_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [WIDTH-1:0] Preset,
  input  logic             Start,
  input  logic             Enable,
  input  logic             Abort,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Expired
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;

  // Next-state and datapath: Abort overrides Start, which overrides Enable.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    expired_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          count_d = Preset;
          presc_d = '0;
          if (Preset != '0) begin
            state_d = S_RUN;
          end else begin
            state_d   = S_DONE;
            expired_d = 1'b1;
          end
        end
      end
      S_RUN, S_HOLD: begin
        // An enabled cycle counts whether we were running or held, so a pause
        // costs exactly as many cycles as Enable was low.
        if (!Enable) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          if (presc_q == PS_LAST) begin
            presc_d = '0;
            if (count_q == WIDTH'(1)) begin
`ifdef PLC_TIMER_AUTO_RELOAD_EN
              expired_d = 1'b1;
              if (Preset != '0) begin
                count_d = Preset;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
`else
              count_d   = '0;
              state_d   = S_DONE;
              expired_d = 1'b1;
`endif
            end else if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (Abort) begin
      state_d   = S_IDLE;
      count_d   = '0;
      presc_d   = '0;
      expired_d = 1'b0;
    end
  end

  // Status flags are derived from the next state so they register with it.
  always_comb begin
    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      presc_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign Count   = count_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Expired = expired_q;

endmodule

// File: tb/tb_plc_down_timer.sv
// Self-checking bench for plc_down_timer: two instances (PRESCALE=2 and
// PRESCALE=1) share stimulus and are compared every cycle against an
// elapsed-tick reference model, plus a vector table and corner sequences.
module tb_plc_down_timer;

  logic       Clock = 1'b0;
  logic       nReset;
  logic [3:0] Preset;
  logic       Start, Enable, Abort;

  logic [3:0] c2, c1;
  logic       b2, d2, x2, b1, d1, x1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  plc_down_timer #(.WIDTH(4), .PRESCALE(2)) u_dut2 (
    .Clock(Clock), .nReset(nReset), .Preset(Preset), .Start(Start),
    .Enable(Enable), .Abort(Abort), .Count(c2), .Busy(b2), .Done(d2),
    .Expired(x2)
  );

  plc_down_timer #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
    .Clock(Clock), .nReset(nReset), .Preset(Preset), .Start(Start),
    .Enable(Enable), .Abort(Abort), .Count(c1), .Busy(b1), .Done(d1),
    .Expired(x1)
  );

  always #5 Clock = ~Clock;

  // Reference model: a run is "P*ps enabled cycles"; Count is derived
  // from how many enabled cycles have elapsed since the load.
  int m_ps  [2] = '{2, 1};
  int m_p   [2];
  int m_el  [2];
  int m_cnt [2];
  bit m_act [2];
  bit m_done[2];
  bit m_exp [2];

  always @(posedge Clock or negedge nReset) begin
    for (int k = 0; k < 2; k++) begin
      if (!nReset || Abort) begin
        m_act[k] = 0; m_done[k] = 0; m_exp[k] = 0; m_el[k] = 0; m_p[k] = 0;
      end else if (!m_act[k] && Start) begin
        m_p[k] = int'(Preset); m_el[k] = 0;
        if (m_p[k] == 0) begin
          m_act[k] = 0; m_done[k] = 1; m_exp[k] = 1;
        end else begin
          m_act[k] = 1; m_done[k] = 0; m_exp[k] = 0;
        end
      end else if (m_act[k] && Enable) begin
        m_el[k]  = m_el[k] + 1;
        m_exp[k] = 0;
        if (m_el[k] == m_p[k] * m_ps[k]) begin
          m_exp[k] = 1;
`ifdef PLC_TIMER_AUTO_RELOAD_EN
          if (Preset != 0) begin
            m_p[k] = int'(Preset); m_el[k] = 0;
          end else begin
            m_act[k] = 0; m_done[k] = 1;
          end
`else
          m_act[k] = 0; m_done[k] = 1;
`endif
        end
      end else begin
        m_exp[k] = 0;
      end
      m_cnt[k] = m_act[k] ? (m_p[k] - m_el[k] / m_ps[k]) : 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    check("model_count_ps2", int'(c2), m_cnt[0]);
    check("model_busy_ps2",  int'(b2), int'(m_act[0]));
    check("model_done_ps2",  int'(d2), int'(m_done[0]));
    check("model_exp_ps2",   int'(x2), int'(m_exp[0]));
    check("model_count_ps1", int'(c1), m_cnt[1]);
    check("model_busy_ps1",  int'(b1), int'(m_act[1]));
    check("model_done_ps1",  int'(d1), int'(m_done[1]));
    check("model_exp_ps1",   int'(x1), int'(m_exp[1]));
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic drive(input logic s, input logic [3:0] p, input logic e, input logic a);
    Start = s; Preset = p; Enable = e; Abort = a;
  endtask

  typedef struct {
    logic       start;
    logic [3:0] preset;
    logic       enable;
    logic       abort;
    logic [3:0] e_count;
    logic       e_busy;
    logic       e_done;
    logic       e_exp;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic s, input logic [3:0] p, input logic e,
                              input logic a, input logic [3:0] c, input logic b,
                              input logic d, input logic x);
    vec_t v;
    v.start = s; v.preset = p; v.enable = e; v.abort = a;
    v.e_count = c; v.e_busy = b; v.e_done = d; v.e_exp = x;
    return v;
  endfunction

  initial begin
    int t0;
    int n;

    // Expectations for the PRESCALE=2 instance.
    tbl[0]  = mk(1, 3, 1, 0, 3, 1, 0, 0);  // accept Preset=3
    tbl[1]  = mk(0, 3, 1, 0, 3, 1, 0, 0);
    tbl[2]  = mk(0, 3, 1, 0, 2, 1, 0, 0);
    tbl[3]  = mk(0, 3, 1, 0, 2, 1, 0, 0);
    tbl[4]  = mk(0, 3, 1, 0, 1, 1, 0, 0);
    tbl[5]  = mk(0, 3, 1, 0, 1, 1, 0, 0);
    tbl[6]  = mk(0, 3, 1, 0, 0, 0, 1, 1);  // Done 6 cycles after accept
    tbl[7]  = mk(0, 3, 1, 0, 0, 0, 1, 0);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 1, 1);  // zero-length restart from DONE
    tbl[9]  = mk(0, 0, 1, 0, 0, 0, 1, 0);
    tbl[10] = mk(1, 5, 1, 1, 0, 0, 0, 0);  // Abort beats Start in DONE
    tbl[11] = mk(0, 5, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 3, 1, 0, 3, 1, 0, 0);
    tbl[13] = mk(1, 9, 1, 0, 3, 1, 0, 0);  // Start ignored mid-count
    tbl[14] = mk(1, 9, 1, 0, 2, 1, 0, 0);
    tbl[15] = mk(0, 9, 0, 0, 2, 1, 0, 0);  // hold
    tbl[16] = mk(0, 9, 0, 0, 2, 1, 0, 0);
    tbl[17] = mk(1, 9, 1, 0, 2, 1, 0, 0);  // Start at Count=2 ignored
    tbl[18] = mk(0, 9, 1, 0, 1, 1, 0, 0);
    tbl[19] = mk(0, 9, 1, 1, 0, 0, 0, 0);  // Abort mid-run

    nReset = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge Clock);
    #1;
    check("reset_count", int'(c2), 0);
    check("reset_busy",  int'(b2), 0);
    check("reset_done",  int'(d2), 0);
    nReset = 1'b1;
    cycle();

`ifndef PLC_TIMER_AUTO_RELOAD_EN
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].start, tbl[i].preset, tbl[i].enable, tbl[i].abort);
      cycle();
      check($sformatf("tbl%0d_count", i), int'(c2), int'(tbl[i].e_count));
      check($sformatf("tbl%0d_busy",  i), int'(b2), int'(tbl[i].e_busy));
      check($sformatf("tbl%0d_done",  i), int'(d2), int'(tbl[i].e_done));
      check($sformatf("tbl%0d_exp",   i), int'(x2), int'(tbl[i].e_exp));
    end

    // Pause: Enable low for 5 cycles after the first decrement.
    drive(0, 0, 0, 1); cycle();
    drive(1, 4, 1, 0); cycle();
    t0 = cyc;
    Start = 0;
    cycle(); cycle();
    check("pause_first_dec", int'(c2), 3);
    Enable = 0;
    repeat (5) begin
      cycle();
      check("pause_frozen", int'(c2), 3);
      check("pause_busy",   int'(b2), 1);
    end
    Enable = 1;
    n = 0;
    while (!d2 && n < 40) begin cycle(); n++; end
    check("pause_total_cycles", cyc - t0, 13);

    // Zero preset from IDLE: never busy, single Expired pulse.
    drive(0, 0, 0, 1); cycle();
    drive(1, 0, 1, 0); cycle();
    check("zero_done", int'(d2), 1);
    check("zero_exp",  int'(x2), 1);
    check("zero_busy", int'(b2), 0);
    Start = 0; cycle();
    check("zero_exp_single", int'(x2), 0);
    check("zero_busy_after", int'(b2), 0);

    // Full-scale preset with PRESCALE=1.
    drive(1, 15, 1, 0); cycle();
    t0 = cyc;
    Start = 0;
    n = 0;
    while (!d1 && n < 40) begin cycle(); n++; end
    check("p15_cycles", cyc - t0, 15);
    repeat (3) begin
      cycle();
      check("p15_no_wrap", int'(c1), 0);
    end
`else
    // Reload loop: Count 2,1,2,1... with Expired every 2 cycles.
    drive(1, 2, 1, 0); cycle();
    check("reload_load", int'(c1), 2);
    Start = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("reload_count", int'(c1), (i % 2 == 0) ? 1 : 2);
      check("reload_exp",   int'(x1), (i % 2 == 0) ? 0 : 1);
      check("reload_done",  int'(d1), 0);
    end
    Abort = 1; cycle();
    check("reload_abort_count", int'(c1), 0);
    check("reload_abort_busy",  int'(b1), 0);
    Abort = 0;
`endif

    // Asynchronous reset mid-run with Count=5.
    drive(0, 0, 0, 1); cycle();
    drive(1, 5, 1, 0); cycle();
    Start = 0;
    check("rst_pre_count", int'(c2), 5);
    nReset = 1'b0;
    #1;
    check("rst_async_count", int'(c2), 0);
    check("rst_async_busy",  int'(b2), 0);
    check("rst_async_done",  int'(d2), 0);
    check("rst_async_exp",   int'(x2), 0);
    @(negedge Clock);
    nReset = 1'b1;
    cycle();
    check("rst_idle_busy",  int'(b2), 0);
    check("rst_idle_count", int'(c2), 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 6)),
            ($urandom_range(0, 4) != 0), ($urandom_range(0, 29) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
